// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER memory arbiter.
// Holds FSM states, owner encoding, default line size and a line-align helper.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int DEF_WORDS_PER_LINE = 4;

   // Clear the low offw bits of an address (byte offset within the line).
   function automatic logic [31:0] line_base(
      input logic [31:0] a,
      input int          offw
   );
      logic [31:0] mask;
      mask = ~((32'd1 << offw) - 32'd1);
      return a & mask;
   endfunction

endpackage

// File: rtl/Mult2to1.sv
// Generic 32-bit two-input multiplexer.
// Ports: In1 (Sel=0), In2 (Sel=1), Sel, Out.
module Mult2to1 (
   input  logic [31:0] In1,
   input  logic [31:0] In2,
   input  logic        Sel,
   output logic [31:0] Out
);

   assign Out = Sel ? In2 : In1;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D cache line-burst arbiter in front of a single memory port.
// Ports: CLK/RST, I_* and D_* requesters, MEM_* beat port, SEL/BEAT/RDATA_VALID/done pulses.
module mem_arbiter
   import otter_mem_pkg::*;
#(
   parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              I_REQ,
   input  logic [31:0]                       I_ADDR,
   input  logic                              D_REQ,
   input  logic                              D_WE,
   input  logic [31:0]                       D_ADDR,
   input  logic [31:0]                       D_WDATA,
   input  logic                              MEM_READY,
   input  logic [31:0]                       MEM_RDATA,
   output logic                              MEM_VALID,
   output logic                              MEM_WE,
   output logic [31:0]                       MEM_ADDR,
   output logic [31:0]                       MEM_WDATA,
   output logic                              SEL,
   output logic [$clog2(WORDS_PER_LINE)-1:0] BEAT,
   output logic                              RDATA_VALID,
   output logic                              I_DONE,
   output logic                              D_DONE
);

   localparam int BW   = $clog2(WORDS_PER_LINE);
   localparam int OFFW = $clog2(WORDS_PER_LINE * 4);
   localparam logic [BW-1:0] LAST = BW'(WORDS_PER_LINE - 1);

   arb_state_t    state_q, state_d;
   owner_t        sel_q, sel_d;
   owner_t        last_q, last_d;
   owner_t        gnt;
   logic          we_q, we_d;
   logic [31:0]   base_q, base_d;
   logic [31:0]   addr_q, addr_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          valid_q, valid_d;
   logic          idone_q, idone_d;
   logic          ddone_q, ddone_d;

   // Read data is consumed by the caches directly; line offsets are masked off.
   logic unused_bits;
   assign unused_bits = ^{MEM_RDATA, I_ADDR[OFFW-1:0], D_ADDR[OFFW-1:0]};

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      we_d    = we_q;
      base_d  = base_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      valid_d = valid_q;
      idone_d = 1'b0;
      ddone_d = 1'b0;
      gnt     = OWN_I;
      unique case (state_q)
         IDLE: begin
            if (I_REQ || D_REQ) begin
               // On a tie, the side that did not win last time goes first.
               if (I_REQ && D_REQ)
                  gnt = (last_q == OWN_I) ? OWN_D : OWN_I;
               else
                  gnt = D_REQ ? OWN_D : OWN_I;
               sel_d   = gnt;
               we_d    = (gnt == OWN_D) && D_WE;
               base_d  = (gnt == OWN_D) ? line_base(D_ADDR, OFFW)
                                        : line_base(I_ADDR, OFFW);
               addr_d  = base_d;
               beat_d  = '0;
               valid_d = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            if (MEM_READY) begin
               if (beat_q == LAST) begin
                  beat_d  = '0;
                  addr_d  = base_q;
                  valid_d = 1'b0;
                  idone_d = (sel_q == OWN_I);
                  ddone_d = (sel_q == OWN_D);
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + BW'(1);
                  addr_d = addr_q + 32'd4;
               end
            end
         end
         DONE: begin
            last_d  = sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         sel_q   <= OWN_I;
         last_q  <= OWN_I;
         we_q    <= 1'b0;
         base_q  <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
         valid_q <= 1'b0;
         idone_q <= 1'b0;
         ddone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         we_q    <= we_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
         idone_q <= idone_d;
         ddone_q <= ddone_d;
      end
   end

   Mult2to1 u_wdata_mux (
      .In1 (32'd0),
      .In2 (D_WDATA),
      .Sel (sel_q),
      .Out (MEM_WDATA)
   );

   assign MEM_VALID   = valid_q;
   assign MEM_WE      = we_q;
   assign MEM_ADDR    = addr_q;
   assign SEL         = sel_q;
   assign BEAT        = beat_q;
   assign I_DONE      = idone_q;
   assign D_DONE      = ddone_q;
   assign RDATA_VALID = (state_q == BURST) && MEM_READY && !we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WORDS_PER_LINE = 4).
// Checks bursts, round-robin tie, write-back stalls, async reset abort, early request drop.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_REQ, D_REQ, D_WE, MEM_READY;
   logic [31:0] I_ADDR, D_ADDR, D_WDATA, MEM_RDATA;
   logic        MEM_VALID, MEM_WE, SEL, RDATA_VALID, I_DONE, D_DONE;
   logic [31:0] MEM_ADDR, MEM_WDATA;
   logic [1:0]  BEAT;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.WORDS_PER_LINE(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .I_REQ       (I_REQ),
      .I_ADDR      (I_ADDR),
      .D_REQ       (D_REQ),
      .D_WE        (D_WE),
      .D_ADDR      (D_ADDR),
      .D_WDATA     (D_WDATA),
      .MEM_READY   (MEM_READY),
      .MEM_RDATA   (MEM_RDATA),
      .MEM_VALID   (MEM_VALID),
      .MEM_WE      (MEM_WE),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_WDATA   (MEM_WDATA),
      .SEL         (SEL),
      .BEAT        (BEAT),
      .RDATA_VALID (RDATA_VALID),
      .I_DONE      (I_DONE),
      .D_DONE      (D_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin : stim
      int b;
      int k;
      int pulses;
      RST = 1'b0; I_REQ = 0; D_REQ = 0; D_WE = 0; MEM_READY = 0;
      I_ADDR = 0; D_ADDR = 0; D_WDATA = 32'hDEADBEEF; MEM_RDATA = 32'h0;
      #2;
      chk("rst_valid", MEM_VALID, 0);
      chk("rst_addr", MEM_ADDR, 0);
      chk("rst_sel", SEL, 0);
      chk("rst_beat", BEAT, 0);
      chk("rst_done", {I_DONE, D_DONE}, 0);
      step(); step();
      RST = 1'b1;

      // I-only fill, ready tied high
      I_REQ = 1; I_ADDR = 32'h0000_1234; MEM_READY = 1;
      #1;
      chk("t1_c0_valid", MEM_VALID, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_valid", MEM_VALID, 1);
         chk("t1_addr", MEM_ADDR, 32'h1230 + 32'(4 * i));
         chk("t1_beat", BEAT, 32'(i));
         chk("t1_sel", SEL, 0);
         chk("t1_we", MEM_WE, 0);
         chk("t1_wdata", MEM_WDATA, 0);
         chk("t1_rvalid", RDATA_VALID, 1);
         chk("t1_idone", I_DONE, 0);
      end
      step();
      chk("t1_c5_idone", I_DONE, 1);
      chk("t1_c5_valid", MEM_VALID, 0);
      chk("t1_c5_beat", BEAT, 0);
      chk("t1_c5_rvalid", RDATA_VALID, 0);
      I_REQ = 0;
      step();
      chk("t1_c6_idone", I_DONE, 0);

      // Simultaneous requests after reset: D wins first
      RST = 1'b0;
      step();
      RST = 1'b1;
      I_REQ = 1; I_ADDR = 32'h3000;
      D_REQ = 1; D_WE = 0; D_ADDR = 32'h2008;
      step();
      chk("t2_d_sel", SEL, 1);
      chk("t2_d_addr", MEM_ADDR, 32'h2000);
      chk("t2_d_valid", MEM_VALID, 1);
      step(); step(); step();
      chk("t2_d_addr3", MEM_ADDR, 32'h200C);
      step();
      chk("t2_ddone", D_DONE, 1);
      chk("t2_idone0", I_DONE, 0);
      D_REQ = 0;
      step();
      chk("t2_idle_valid", MEM_VALID, 0);
      chk("t2_idle_ddone", D_DONE, 0);
      step();
      chk("t2_i_sel", SEL, 0);
      chk("t2_i_valid", MEM_VALID, 1);
      chk("t2_i_addr", MEM_ADDR, 32'h3000);
      step(); step(); step();
      step();
      chk("t2_idone", I_DONE, 1);
      I_REQ = 0;
      step();

      // D write-back with alternating ready
      D_REQ = 1; D_WE = 1; D_ADDR = 32'h4010; MEM_READY = 0;
      step();
      b = 0; k = 0;
      while (b < 4 && k < 20) begin
         MEM_READY = (k % 2 == 0);
         D_WDATA = 32'hA500_0000 + 32'(k);
         #1;
         chk("t3_valid", MEM_VALID, 1);
         chk("t3_addr", MEM_ADDR, 32'h4010 + 32'(4 * b));
         chk("t3_beat", BEAT, 32'(b));
         chk("t3_we", MEM_WE, 1);
         chk("t3_rvalid", RDATA_VALID, 0);
         chk("t3_wdata", MEM_WDATA, 32'hA500_0000 + 32'(k));
         if (MEM_READY) b++;
         k++;
         step();
      end
      chk("t3_cycles", k, 7);
      chk("t3_ddone", D_DONE, 1);
      chk("t3_done_rvalid", RDATA_VALID, 0);
      D_REQ = 0; D_WE = 0; MEM_READY = 1;
      step();

      // Async reset mid-burst
      I_REQ = 1; I_ADDR = 32'h5000;
      step(); step(); step();
      chk("t4_beat2", BEAT, 2);
      #2;
      RST = 1'b0;
      #1;
      chk("t4_rst_valid", MEM_VALID, 0);
      chk("t4_rst_beat", BEAT, 0);
      chk("t4_rst_addr", MEM_ADDR, 0);
      step();
      chk("t4_rst_idone", I_DONE, 0);
      RST = 1'b1;
      step();
      chk("t4_re_valid", MEM_VALID, 1);
      chk("t4_re_beat", BEAT, 0);
      chk("t4_re_addr", MEM_ADDR, 32'h5000);
      chk("t4_re_idone", I_DONE, 0);
      step(); step(); step();
      step();
      chk("t4_idone", I_DONE, 1);
      I_REQ = 0;
      step();

      // Request dropped at BEAT=1
      I_REQ = 1; I_ADDR = 32'h6004;
      pulses = 0;
      step();
      chk("t5_beat0_addr", MEM_ADDR, 32'h6000);
      step();
      chk("t5_beat1", BEAT, 1);
      I_REQ = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (I_DONE) pulses++;
         if (i == 1) chk("t5_beat3", BEAT, 3);
         if (i == 2) chk("t5_idone", I_DONE, 1);
      end
      chk("t5_pulses", pulses, 1);
      chk("t5_idle_valid", MEM_VALID, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, giving beats per burst (power of 2, 2..16).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port I_REQ  in  1  I-cache line-fill request, held until I_DONE.
REQ-005 SHALL have port I_ADDR  in  32  I-cache miss address.
REQ-006 SHALL have port D_REQ  in  1  D-cache request, held until D_DONE.
REQ-007 SHALL have port D_WE  in  1  D request type: 1 = line write-back, 0 = line fill.
REQ-008 SHALL have port D_ADDR  in  32  D-cache line address.
REQ-009 SHALL have port D_WDATA  in  32  write-back word for the current BEAT.
REQ-010 SHALL have port MEM_READY  in  1  memory accepts or returns the current beat.
REQ-011 SHALL have port MEM_RDATA  in  32  memory read data, valid when MEM_READY=1.
REQ-012 SHALL have port MEM_VALID  out  1  beat request to memory.
REQ-013 SHALL have port MEM_WE  out  1  beat is a write.
REQ-014 SHALL have port MEM_ADDR  out  32  current beat word address.
REQ-015 SHALL have port MEM_WDATA  out  32  current beat write data.
REQ-016 SHALL have port SEL  out  1  owner select: 0 = I, 1 = D; drives the shared data-path mux.
REQ-017 SHALL have port BEAT  out  $clog2(WORDS_PER_LINE)  word index within the line.
REQ-018 SHALL have port RDATA_VALID  out  1  MEM_RDATA is a fill word for the owner at BEAT.
REQ-019 SHALL have ports I_DONE and D_DONE  out  1 each  one-cycle completion pulses.

Function
REQ-020 SHALL implement FSM states IDLE, BURST and DONE.
REQ-021 In IDLE, with exactly one request asserted, SHALL grant that requester on the next edge and enter BURST.
REQ-022 In IDLE, with both requests asserted, SHALL grant the requester not granted last (round-robin); the last-grant flag resets to I, so D wins the first tie.
REQ-023 On grant, SHALL latch owner, MEM_WE (D_WE for D, 0 for I) and base address (request address with the low $clog2(WORDS_PER_LINE*4) bits cleared), and SHALL set BEAT=0.
REQ-024 In BURST, SHALL drive MEM_VALID=1 and MEM_ADDR = base + BEAT*4, and SHALL drive MEM_WDATA = D_WDATA when SEL=1, else 0.
REQ-025 In BURST, SHALL increment BEAT on each cycle with MEM_READY=1; BEAT and MEM_ADDR SHALL hold while MEM_READY=0.
REQ-026 SHALL assert RDATA_VALID = MEM_READY & ~MEM_WE in BURST; it SHALL be 0 in all other states.
REQ-027 On MEM_READY at BEAT = WORDS_PER_LINE-1, SHALL enter DONE, drive MEM_VALID=0 and wrap BEAT to 0.
REQ-028 In DONE, SHALL pulse the owner's DONE for exactly one cycle, update the last-grant flag, and return to IDLE; the next grant therefore takes at least one further IDLE cycle.
REQ-029 SHALL ignore request deassertion mid-burst; the burst completes and DONE still pulses.
REQ-030 SHALL ignore requests from the non-owner during BURST and DONE, holding them pending.
REQ-031 Latency with MEM_READY tied high: request seen in IDLE at cycle 0; MEM_VALID at cycles 1..W; DONE at cycle W+1; IDLE at cycle W+2.
REQ-032 SHALL register all outputs except RDATA_VALID and MEM_WDATA.

Reset
REQ-033 On RST=0, SHALL asynchronously force state IDLE, MEM_VALID=0, MEM_WE=0, MEM_ADDR=0, SEL=0, BEAT=0, I_DONE=0, D_DONE=0 and last-grant=I, including mid-burst, with no DONE pulse for the aborted burst.
REQ-034 After RST deasserts, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-035 SHALL place the state enum arb_state_t, the owner_t type (OWN_I, OWN_D) and the default WORDS_PER_LINE in shared package otter_mem_pkg.
REQ-036 SHALL select MEM_WDATA through one instance of the existing Mult2to1, with SEL as its select; no other sub-modules.

Verification
REQ-037 SHALL cover: I_REQ only, I_ADDR=0x0000_1234, MEM_READY=1 -> MEM_ADDR 0x1230, 0x1234, 0x1238, 0x123C on cycles 1-4; I_DONE at cycle 5.
REQ-038 SHALL cover: I_REQ and D_REQ asserted in the same cycle after reset -> D granted first (SEL=1); I granted after D_DONE, with one IDLE cycle between.
REQ-039 SHALL cover: D write-back, D_WE=1, MEM_READY toggling 1,0,1,0,… -> each MEM_ADDR holds during stalls, MEM_WE=1 throughout, RDATA_VALID never asserted.
REQ-040 SHALL cover: RST driven low at BEAT=2 between clock edges -> MEM_VALID=0 immediately; no DONE pulse; new I_REQ serviced from BEAT=0.
REQ-041 SHALL cover: I_REQ deasserted at BEAT=1 -> burst runs to BEAT=3 and I_DONE still pulses once.
